// File: rtl/steering_ctrl.sv
// Line-follower steering: per-frame PD correction around a base speed, lost-line
// hold/search FSM and two glitch-free PWM motor outputs.
module steering_ctrl #(
    parameter int unsigned IMG_W        = 640,
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned PWM_DIV      = 1,
    parameter int unsigned BASE_SPEED   = 128,
    parameter int unsigned KP           = 1,
    parameter int unsigned KD           = 0,
    parameter int unsigned CORR_SHIFT   = 0,
    parameter int unsigned LOST_FRAMES  = 8,
    parameter int unsigned SEARCH_SPEED = 96
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(IMG_W):0]    centroid_x,
    input  logic                      line_valid,
    input  logic                      line_lost,
    output logic [PWM_BITS-1:0]       duty_left,
    output logic [PWM_BITS-1:0]       duty_right,
    output logic                      pwm_left,
    output logic                      pwm_right,
    output logic [1:0]                state,
    output logic                      update
);

    localparam int unsigned CX_W   = $clog2(IMG_W) + 1;
    localparam int unsigned ERR_W  = CX_W;
    localparam int unsigned D_W    = ERR_W + 1;
    localparam int unsigned KMAX   = (KP > KD) ? KP : KD;
    localparam int unsigned GAIN_W = $clog2(KMAX + 1) + 1;
    localparam int unsigned ACC_W  = D_W + GAIN_W + PWM_BITS + 2;
    localparam int unsigned DMAX   = (2 ** PWM_BITS) - 1;
    localparam int unsigned CNT_W  = $clog2(LOST_FRAMES + 1);
    localparam int unsigned DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    localparam logic [CX_W-1:0]            CX_MAX   = CX_W'(IMG_W - 1);
    localparam logic [CX_W-1:0]            CX_MID   = CX_W'(IMG_W / 2);
    localparam logic signed [GAIN_W-1:0]   KP_S     = GAIN_W'(KP);
    localparam logic signed [GAIN_W-1:0]   KD_S     = GAIN_W'(KD);
    localparam logic signed [ACC_W-1:0]    BASE_S   = ACC_W'(BASE_SPEED);
    localparam logic signed [ACC_W-1:0]    DMAX_S   = ACC_W'(DMAX);
    localparam logic [PWM_BITS-1:0]        DMAX_D   = PWM_BITS'(DMAX);
    localparam logic [PWM_BITS-1:0]        SEARCH_D = PWM_BITS'(SEARCH_SPEED);
    localparam logic [CNT_W-1:0]           LOST_LIM = CNT_W'(LOST_FRAMES);

    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, HOLD = 2'd2, SEARCH = 2'd3} state_t;

    state_t cur, state_n;

    // Stage 0: frame capture
    logic            s0_valid, s0_lost;
    logic [CX_W-1:0] s0_cx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_lost  <= 1'b0;
            s0_cx    <= '0;
        end else begin
            s0_valid <= line_valid;
            if (line_valid) begin
                s0_lost <= line_lost;
                s0_cx   <= centroid_x;
            end
        end
    end

    // Stage 1: clamp and heading error
    logic [CX_W-1:0]          cx_clamp_c;
    logic signed [ERR_W-1:0]  err_c;
    logic                     s1_valid, s1_lost;
    logic signed [ERR_W-1:0]  s1_err;

    assign cx_clamp_c = (s0_cx > CX_MAX) ? CX_MAX : s0_cx;
    assign err_c      = $signed(cx_clamp_c) - $signed(CX_MID);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_lost  <= 1'b0;
            s1_err   <= '0;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_lost <= s0_lost;
                s1_err  <= err_c;
            end
        end
    end

    // Stage 2: derivative and gain products; search side is latched per frame so
    // it reflects only the non-lost frames that preceded it
    logic signed [ERR_W-1:0] prev_err;
    logic                    have_prev;
    logic signed [D_W-1:0]   d_c;
    logic signed [ACC_W-1:0] pk_c, pd_c;
    logic                    s2_valid, s2_lost, s2_seek_left;
    logic signed [ACC_W-1:0] s2_pk, s2_pd;

    assign d_c  = have_prev ? (D_W'(s1_err) - D_W'(prev_err)) : '0;
    assign pk_c = ACC_W'(s1_err) * ACC_W'(KP_S);
    assign pd_c = ACC_W'(d_c) * ACC_W'(KD_S);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            s2_lost      <= 1'b0;
            s2_seek_left <= 1'b0;
            s2_pk        <= '0;
            s2_pd        <= '0;
            prev_err     <= '0;
            have_prev    <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_lost      <= s1_lost;
                s2_pk        <= pk_c;
                s2_pd        <= pd_c;
                s2_seek_left <= ~prev_err[ERR_W-1];
                if (!s1_lost) begin
                    prev_err  <= s1_err;
                    have_prev <= 1'b1;
                end else begin
                    have_prev <= 1'b0;
                end
            end
        end
    end

    // Stage 3: sum, saturate, lost-line FSM
    function automatic logic [PWM_BITS-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v[ACC_W-1])  return '0;
        if (v > DMAX_S)  return DMAX_D;
        return PWM_BITS'(v);
    endfunction

    logic signed [ACC_W-1:0] sum_c, corr_c;
    logic [PWM_BITS-1:0]     seek_l_c, seek_r_c;
    logic [PWM_BITS-1:0]     duty_left_n, duty_right_n;
    logic [CNT_W-1:0]        lost_cnt, lost_cnt_n;
    logic                    update_n;

    assign sum_c    = s2_pk + s2_pd;
    assign corr_c   = sum_c >>> CORR_SHIFT;
    assign seek_l_c = s2_seek_left ? SEARCH_D : '0;
    assign seek_r_c = s2_seek_left ? '0 : SEARCH_D;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur        <= IDLE;
            duty_left  <= '0;
            duty_right <= '0;
            lost_cnt   <= '0;
            update     <= 1'b0;
        end else begin
            cur        <= state_n;
            duty_left  <= duty_left_n;
            duty_right <= duty_right_n;
            lost_cnt   <= lost_cnt_n;
            update     <= update_n;
        end
    end

    always_comb begin
        state_n      = cur;
        duty_left_n  = duty_left;
        duty_right_n = duty_right;
        lost_cnt_n   = lost_cnt;
        update_n     = 1'b0;
        if (s2_valid) begin
            update_n = 1'b1;
            if (!s2_lost) begin
                state_n      = TRACK;
                duty_left_n  = sat(BASE_S + corr_c);
                duty_right_n = sat(BASE_S - corr_c);
                lost_cnt_n   = '0;
            end else begin
                case (cur)
                    IDLE: begin
                        duty_left_n  = '0;
                        duty_right_n = '0;
                    end
                    TRACK: begin
                        lost_cnt_n = CNT_W'(1);
                        if (LOST_FRAMES <= 1) begin
                            state_n      = SEARCH;
                            duty_left_n  = seek_l_c;
                            duty_right_n = seek_r_c;
                        end else begin
                            state_n = HOLD;
                        end
                    end
                    HOLD: begin
                        lost_cnt_n = lost_cnt + CNT_W'(1);
                        if (lost_cnt_n >= LOST_LIM) begin
                            state_n      = SEARCH;
                            duty_left_n  = seek_l_c;
                            duty_right_n = seek_r_c;
                        end
                    end
                    default: begin
                        state_n = SEARCH;
                    end
                endcase
            end
        end
    end

    assign state = cur;

    // PWM: duties are adopted only at counter wrap so a period is never truncated
    logic [DIV_W-1:0]    div_cnt, div_n;
    logic [PWM_BITS-1:0] pwm_cnt, cnt_n, act_l, act_r, act_l_n, act_r_n;
    logic                step_c, wrap_c;

    assign step_c  = (div_cnt == DIV_W'(PWM_DIV - 1));
    assign div_n   = step_c ? '0 : div_cnt + DIV_W'(1);
    assign cnt_n   = step_c ? pwm_cnt + PWM_BITS'(1) : pwm_cnt;
    assign wrap_c  = step_c && (pwm_cnt == DMAX_D);
    assign act_l_n = wrap_c ? duty_left : act_l;
    assign act_r_n = wrap_c ? duty_right : act_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            pwm_cnt   <= '0;
            act_l     <= '0;
            act_r     <= '0;
            pwm_left  <= 1'b0;
            pwm_right <= 1'b0;
        end else begin
            div_cnt   <= div_n;
            pwm_cnt   <= cnt_n;
            act_l     <= act_l_n;
            act_r     <= act_r_n;
            pwm_left  <= (cnt_n < act_l_n);
            pwm_right <= (cnt_n < act_r_n);
        end
    end

endmodule
